// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // An all-zero instruction word is the pipeline bubble.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    // FETCH: request in flight or about to be issued.
    // HOLD : no request; one fetched word is parked in the buffer.
    // DRAIN: request still in flight but its response belongs to a squashed path.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_bubble,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc4,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc4;
    logic               r_valid;

    // Bubble wins over load so a squash can never let a stale word through.
    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM, one-entry stall buffer and IF/ID register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write_en,
    input  logic               ifid_write_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_pending_pc;
    logic [INSTR_W-1:0] r_buf;

    logic               w_advance;
    logic [ADDR_W-1:0]  w_pc4;
    logic [ADDR_W-1:0]  w_redirect_pc;
    logic               w_ifid_load;
    logic               w_ifid_bubble;
    logic [INSTR_W-1:0] w_ifid_instr;

    // A disagreement between the two stall enables is treated as a stall.
    assign w_advance     = pc_write_en & ifid_write_en;
    assign w_pc4         = r_pc + ADDR_W'(4);
    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);

    // The address comes only from the PC register, so it is stable until ack.
    assign imem_req  = (r_state != HOLD);
    assign imem_addr = r_pc;

    // Decide what the IF/ID register does this cycle.
    always_comb begin
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_instr  = imem_rdata;
        if (redirect_valid) begin
            w_ifid_bubble = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_advance) begin
                        if (imem_ack) w_ifid_load   = 1'b1;
                        else          w_ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (w_advance) begin
                        w_ifid_load  = 1'b1;
                        w_ifid_instr = r_buf;
                    end
                end
                DRAIN: begin
                    // The response in flight is dead, so nothing real can enter.
                    if (w_advance) w_ifid_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM together with PC, pending redirect target and stall buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
            r_buf        <= INSTR_W'(NOP_INSTR);
        end else if (redirect_valid) begin
            r_buf <= INSTR_W'(NOP_INSTR);
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_pc <= w_redirect_pc;
                    end else begin
                        r_pending_pc <= w_redirect_pc;
                        r_state      <= DRAIN;
                    end
                end
                HOLD: begin
                    r_pc    <= w_redirect_pc;
                    r_state <= FETCH;
                end
                DRAIN: begin
                    // Latest redirect wins while the old response is still due.
                    r_pending_pc <= w_redirect_pc;
                    if (imem_ack) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        if (w_advance) begin
                            r_pc <= w_pc4;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_advance) begin
                        r_pc    <= w_pc4;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        r_pc    <= r_pending_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_ifid_load),
        .i_bubble (w_ifid_bubble),
        .i_instr  (w_ifid_instr),
        .i_pc4    (w_pc4),
        .o_instr  (ifid_instr),
        .o_pc4    (ifid_pc4),
        .o_valid  (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifid_instr     (ifid_instr),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic ack, input logic pcw, input logic ifw,
                       input logic rv, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        pc_write_en    = pcw;
        ifid_write_en  = ifw;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid);
        chk({tag, "_instr"}, ifid_instr, instr);
        chk({tag, "_pc4"}, ifid_pc4, pc4);
        chk({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
        $display("ifid %-12s instr=%h pc4=%h valid=%0b", tag, ifid_instr, ifid_pc4, ifid_valid);
    endtask

    task automatic expect_bubble(input string tag);
        expect_ifid(tag, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic expect_load(input string tag);
        exp_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            expect_ifid(tag, e.instr, e.pc4, 1'b1);
        end
    endtask

    // Zero-wait fetch of one word with the pipeline advancing.
    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        exp_t e;
        logic [31:0] nxt;
        nxt = addr + 32'd4;
        check_req(tag, 1'b1, addr);
        e.instr = mem_word(addr);
        e.pc4   = nxt;
        sb.push_back(e);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_load(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        expect_bubble("reset");
        check_req("reset", 1'b1, 32'd0);
        reset = 1'b0;

        // 1: zero-wait memory, one instruction per cycle.
        for (int i = 0; i < 4; i++) expect_fetch("zw", 32'(i * 4));

        // 2: three wait cycles at 0x10.
        for (int i = 0; i < 3; i++) begin
            check_req("wait", 1'b1, 32'h10);
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            expect_bubble("wait");
        end
        expect_fetch("wait_ack", 32'h10);
        for (int i = 0; i < 3; i++) expect_fetch("fill", 32'h14 + 32'(i * 4));

        // 3: stall on the ack cycle for 0x20, including an enable mismatch.
        check_req("hold0", 1'b1, 32'h20);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check_req("hold1", 1'b0, 32'd0);
        expect_ifid("hold1", mem_word(32'h1C), 32'h20, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_req("hold2", 1'b0, 32'd0);
        expect_ifid("hold2", mem_word(32'h1C), 32'h20, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check_req("hold3", 1'b0, 32'd0);
        expect_ifid("hold3", mem_word(32'h1C), 32'h20, 1'b1);
        sb.push_back('{instr: mem_word(32'h20), pc4: 32'h24});
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_load("release");
        for (int i = 0; i < 7; i++) expect_fetch("run", 32'h24 + 32'(i * 4));

        // 4: redirect to 0x100 while 0x40 is outstanding.
        check_req("rd0", 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        expect_bubble("rd1");
        check_req("rd1", 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_bubble("rd2");
        check_req("rd2", 1'b1, 32'h40);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_bubble("rd3");
        expect_fetch("rd_tgt", 32'h100);

        // 5: two redirects while draining; latest wins; low bits ignored.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        check_req("dr1", 1'b1, 32'h104);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        check_req("dr2", 1'b1, 32'h104);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        check_req("dr3", 1'b1, 32'h300);
        expect_bubble("dr3");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h303);
        check_req("unal", 1'b1, 32'h300);
        expect_bubble("unal");
        expect_fetch("unal_f", 32'h300);

        // 6: PC wrap, then reset during a wait state.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_fetch("wrap", 32'hFFFF_FFFC);
        expect_fetch("wrap0", 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        expect_ifid("stallw", mem_word(32'd0), 32'd4, 1'b1);
        check_req("stallw", 1'b1, 32'd4);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        expect_bubble("rst2");
        check_req("rst2", 1'b1, 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
